// File: rtl/urex7_sprite_fetch.sv
// urex7 sprite fetch: hit test, sprite ROM addressing and palette index output.
// Fixed three-stage pipeline, one pixel per clock, frame-latched sprite controls.
module urex7_sprite_fetch #(
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter int          FRAMES      = 2,
    parameter int          FRAME_DIV   = 8,
    parameter logic [3:0]  TRANSPARENT = 4'h0,
    localparam int         AW          = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          frame_start,
    input  logic [9:0]    draw_x,
    input  logic [9:0]    draw_y,
    input  logic [9:0]    pos_x,
    input  logic [9:0]    pos_y,
    input  logic          flip_x,
    input  logic          spr_en,
    input  logic          anim_en,
    output logic [AW-1:0] rom_addr,
    input  logic [3:0]    rom_data,
    output logic [3:0]    pix_index,
    output logic          pix_opaque
);

    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [9:0]    pos_x_q, pos_x_d;
    logic [9:0]    pos_y_q, pos_y_d;
    logic          flip_q, flip_d;
    logic          spr_en_q, spr_en_d;
    logic [7:0]    div_cnt_q, div_cnt_d;
    logic [FW-1:0] frame_idx_q, frame_idx_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          hit0_q, hit0_d;
    logic          hit1_q, hit1_d;
    logic [3:0]    pix_index_q, pix_index_d;
    logic          pix_opaque_q, pix_opaque_d;

    logic [10:0]   dx, dy;
    logic [XW-1:0] col;
    logic          hit;

    always_comb begin
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        flip_d       = flip_q;
        spr_en_d     = spr_en_q;
        div_cnt_d    = div_cnt_q;
        frame_idx_d  = frame_idx_q;

        if (frame_start) begin
            pos_x_d  = pos_x;
            pos_y_d  = pos_y;
            flip_d   = flip_x;
            spr_en_d = spr_en;
            if (anim_en) begin
                if (div_cnt_q == 8'(FRAME_DIV - 1)) begin
                    div_cnt_d   = '0;
                    frame_idx_d = (FRAMES > 1) ? frame_idx_q + 1'b1 : '0;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
        end

        // Off-sprite pixels to the left/above wrap to huge offsets and miss.
        dx  = {1'b0, draw_x} - {1'b0, pos_x_q};
        dy  = {1'b0, draw_y} - {1'b0, pos_y_q};
        hit = spr_en_q & (dx < 11'(SPR_W)) & (dy < 11'(SPR_H));
        col = flip_q ? XW'(SPR_W - 1) - dx[XW-1:0] : dx[XW-1:0];

        rom_addr_d = '0;
        if (hit) begin
            rom_addr_d = AW'(frame_idx_q) * AW'(SPR_W * SPR_H)
                       + AW'(dy[YW-1:0]) * AW'(SPR_W)
                       + AW'(col);
        end

        hit0_d       = hit;
        hit1_d       = hit0_q;
        pix_index_d  = hit1_q ? rom_data : TRANSPARENT;
        pix_opaque_d = hit1_q & (rom_data != TRANSPARENT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            flip_q       <= 1'b0;
            spr_en_q     <= 1'b0;
            div_cnt_q    <= '0;
            frame_idx_q  <= '0;
            rom_addr_q   <= '0;
            hit0_q       <= 1'b0;
            hit1_q       <= 1'b0;
            pix_index_q  <= TRANSPARENT;
            pix_opaque_q <= 1'b0;
        end else begin
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            flip_q       <= flip_d;
            spr_en_q     <= spr_en_d;
            div_cnt_q    <= div_cnt_d;
            frame_idx_q  <= frame_idx_d;
            rom_addr_q   <= rom_addr_d;
            hit0_q       <= hit0_d;
            hit1_q       <= hit1_d;
            pix_index_q  <= pix_index_d;
            pix_opaque_q <= pix_opaque_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pix_index  = pix_index_q;
    assign pix_opaque = pix_opaque_q;

endmodule

// File: tb/tb_urex7_sprite_fetch.sv
// Bench for urex7_sprite_fetch: directed and random pixels against a
// frame-level reference model, checked by a queue-driven monitor.
module tb_urex7_sprite_fetch;

    localparam int         SPR_W  = 32;
    localparam int         SPR_H  = 32;
    localparam int         FRAMES = 2;
    localparam int         FDIV   = 8;
    localparam logic [3:0] TRANSP = 4'h0;
    localparam int         AW     = $clog2(FRAMES * SPR_W * SPR_H);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [9:0]    draw_x = '0, draw_y = '0, pos_x = '0, pos_y = '0;
    logic          flip_x = 1'b0, spr_en = 1'b0, anim_en = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [3:0]    rom_data = '0;
    logic [3:0]    pix_index;
    logic          pix_opaque;

    urex7_sprite_fetch #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES),
        .FRAME_DIV(FDIV), .TRANSPARENT(TRANSP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .draw_x(draw_x), .draw_y(draw_y), .pos_x(pos_x), .pos_y(pos_y),
        .flip_x(flip_x), .spr_en(spr_en), .anim_en(anim_en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_index(pix_index), .pix_opaque(pix_opaque)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [0:(1<<AW)-1];
    always @(posedge clk) rom_data <= mem[rom_addr];

    typedef struct {
        int addr;
        bit hit;
        bit rst;
        int due;
    } item_t;

    item_t addr_q[$];
    item_t pix_q[$];
    int    checks = 0;
    int    errors = 0;
    int    edge_n = 0;

    // Reference state: latched controls and total count of animated pulses.
    int m_px = 0, m_py = 0, m_anim = 0;
    bit m_fl = 0, m_en = 0;

    always @(posedge clk) begin
        item_t it;
        item_t pt;
        logic [3:0] e_idx;
        bit         e_op;
        #1;
        edge_n++;
        if (addr_q.size() > 0) begin
            it = addr_q.pop_front();
            if (it.rst) begin
                foreach (pix_q[i])
                    if (pix_q[i].due <= edge_n + 1) pix_q[i].hit = 0;
            end
            checks++;
            if (rom_addr !== AW'(it.addr)) begin
                errors++;
                $display("FAIL rom_addr edge %0d: got %0d want %0d",
                         edge_n, rom_addr, it.addr);
            end
            it.due = edge_n + 2;
            pix_q.push_back(it);
        end
        if (pix_q.size() > 0 && pix_q[0].due == edge_n) begin
            pt    = pix_q.pop_front();
            e_idx = pt.hit ? mem[pt.addr] : TRANSP;
            e_op  = pt.hit && (mem[pt.addr] != TRANSP);
            checks++;
            if (pix_index !== e_idx || pix_opaque !== e_op) begin
                errors++;
                $display("FAIL pixel edge %0d: got idx %0d op %0b want idx %0d op %0b",
                         edge_n, pix_index, pix_opaque, e_idx, e_op);
            end
        end
    end

    task automatic step(input bit rst, input bit fs, input int x, input int y,
                        input int px, input int py, input bit fl,
                        input bit en, input bit an);
        item_t it;
        int dx, dy, col, frame;
        @(negedge clk);
        reset_n     = !rst;
        frame_start = fs;
        draw_x      = 10'(x);
        draw_y      = 10'(y);
        pos_x       = 10'(px);
        pos_y       = 10'(py);
        flip_x      = fl;
        spr_en      = en;
        anim_en     = an;
        it.rst  = rst;
        it.due  = 0;
        it.hit  = 0;
        it.addr = 0;
        if (!rst) begin
            dx = ((x & 1023) - m_px) & 2047;
            dy = ((y & 1023) - m_py) & 2047;
            it.hit = m_en && dx < SPR_W && dy < SPR_H;
            if (it.hit) begin
                col     = m_fl ? SPR_W - 1 - dx : dx;
                frame   = (m_anim / FDIV) % FRAMES;
                it.addr = frame * SPR_W * SPR_H + dy * SPR_W + col;
            end
        end
        addr_q.push_back(it);
        if (rst) begin
            m_px = 0; m_py = 0; m_fl = 0; m_en = 0; m_anim = 0;
        end else if (fs) begin
            m_px = px & 1023;
            m_py = py & 1023;
            m_fl = fl;
            m_en = en;
            if (an) m_anim++;
        end
        @(posedge clk);
    endtask

    task automatic chk_addr(input int want, input string nm);
        #1;
        checks++;
        if (rom_addr !== AW'(want)) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, rom_addr, want);
        end
    endtask

    initial begin
        int x, y, px, py;
        bit fs, rst, fl, en, an;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 4'($urandom_range(0, 15));
        mem[67]  = 4'h5;
        mem[330] = TRANSP;

        for (int i = 0; i < 3; i++)
            step(1, 1, $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), $urandom_range(0, 1023), 1, 1, 1);
        chk_addr(0, "reset_addr");

        step(0, 1, 0, 0, 100, 50, 0, 1, 0);
        step(0, 0, 103, 52, 100, 50, 0, 1, 0);
        chk_addr(67, "basic_hit");

        step(0, 1, 0, 0, 100, 50, 1, 1, 0);
        step(0, 0, 103, 52, 100, 50, 1, 1, 0);
        chk_addr(92, "flip_hit");
        step(0, 0, 99, 52, 100, 50, 1, 1, 0);
        chk_addr(0, "left_miss");
        step(0, 0, 132, 52, 100, 50, 1, 1, 0);
        chk_addr(0, "right_miss");

        step(0, 1, 0, 0, 620, 0, 0, 1, 0);
        step(0, 0, 639, 0, 620, 0, 0, 1, 0);
        chk_addr(19, "edge_clip");

        step(0, 1, 0, 0, 100, 50, 0, 1, 0);
        step(0, 0, 110, 60, 100, 50, 0, 1, 0);
        chk_addr(330, "transparent");

        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 100, 50, 0, 1, 1);
        step(0, 0, 100, 50, 100, 50, 0, 1, 1);
        chk_addr(1024, "anim_frame1");
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 100, 50, 0, 1, 1);
        step(0, 0, 101, 50, 100, 50, 0, 1, 1);
        chk_addr(1, "anim_wrap");
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 100, 50, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 100, 50, 0, 1, 0);
        step(0, 0, 100, 50, 100, 50, 0, 1, 0);
        chk_addr(1024, "anim_freeze");

        step(0, 0, 103, 52, 200, 50, 0, 1, 0);
        chk_addr(1091, "no_latch_midframe");
        step(0, 1, 103, 52, 200, 50, 0, 1, 0);
        chk_addr(1091, "fs_coincident");
        step(0, 0, 103, 52, 200, 50, 0, 1, 0);
        chk_addr(0, "new_pos_applied");

        step(1, 0, 205, 55, 200, 50, 0, 1, 0);
        step(0, 0, 205, 55, 200, 50, 0, 1, 0);
        chk_addr(0, "post_reset_off");

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            fs  = ($urandom_range(0, 49) == 0);
            px  = $urandom_range(0, 639);
            py  = $urandom_range(0, 479);
            fl  = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 7) != 0);
            an  = ($urandom_range(0, 3) != 0);
            x   = (m_px + $urandom_range(0, 48) - 8) & 1023;
            y   = (m_py + $urandom_range(0, 48) - 8) & 1023;
            step(rst, fs, x, y, px, py, fl, en, an);
        end

        for (int i = 0; i < 20 && (addr_q.size() > 0 || pix_q.size() > 0); i++)
            @(posedge clk);
        #2;
        if (addr_q.size() > 0 || pix_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d addr and %0d pixel items left, want 0",
                     addr_q.size(), pix_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
